// File: rtl/sc_sched_pkg.sv
// Shared types and constants for the sc_sched time-slice scheduler.
package sc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        DRAIN = 2'b10
    } state_e;

    localparam int unsigned CNT_W         = 3;
    localparam int unsigned SLICE_MAX_DEF = 5;

    function automatic int unsigned wrap_inc(
        input int unsigned idx,
        input int unsigned n
    );
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/slice_ctr.sv
// Saturating slice counter; flags any value above the saturation point.
module slice_ctr
    import sc_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] max,
    output logic [CNT_W-1:0] cnt,
    output logic             sat,
    output logic             bad
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q < max)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = (cnt_q == max);
    assign bad = (cnt_q > max);

endmodule

// File: rtl/sc_sched.sv
// Round-robin time-slice scheduler: one owner at a time, one idle
// DRAIN cycle between owners, shared saturating slice counter.
module sc_sched
    import sc_sched_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int SLICE_MAX = SLICE_MAX_DEF,
    localparam int IW        = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  done,
    output logic [NREQ-1:0]  gnt,
    output logic             gnt_valid,
    output logic [IW-1:0]    gnt_id,
    output logic [CNT_W-1:0] slice_cnt,
    output logic             err
);

    state_e          state_q;
    state_e          state_d;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] gnt_d;
    logic [IW-1:0]   id_q;
    logic [IW-1:0]   id_d;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   ptr_d;

    logic [IW-1:0]   win;
    logic [IW-1:0]   idx;
    logic            found;
    logic [NREQ-1:0] win_oh;

    logic [CNT_W-1:0] cnt;
    logic             sat;
    logic             bad;
    logic             clr;
    logic             en;
    logic             other;
    logic             exit_c;
    logic             bad_state;

    // First set request at or after ptr, wrapping.
    always_comb begin
        win   = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IW'((int'(ptr_q) + i) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_oh      = '0;
        win_oh[win] = 1'b1;
    end

    assign other  = |(req & ~gnt_q);
    assign exit_c = !req[id_q] || done[id_q] || (sat && other);

    assign bad_state = (state_q != IDLE) &&
                       (state_q != GRANT) &&
                       (state_q != DRAIN);
    assign err = bad_state || bad;

    assign en  = (state_q == GRANT);
    assign clr = err || (state_q != GRANT) || exit_c;

    slice_ctr u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (en),
        .max   (CNT_W'(SLICE_MAX)),
        .cnt   (cnt),
        .sat   (sat),
        .bad   (bad)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (err) begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
        end else begin
            unique case (state_q)
                IDLE, DRAIN: begin
                    if (|req) begin
                        state_d = GRANT;
                        gnt_d   = win_oh;
                        id_d    = win;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        id_d    = '0;
                    end
                end
                GRANT: begin
                    if (exit_c) begin
                        state_d = DRAIN;
                        gnt_d   = '0;
                        id_d    = '0;
                        ptr_d   = IW'(wrap_inc(
                                      int'(id_q), NREQ));
                    end
                end
                default: begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    id_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = id_q;
    assign slice_cnt = cnt;

endmodule

// File: tb/tb_sc_sched.sv
// Scoreboard bench for sc_sched: directed vectors queue expected
// outputs, a monitor compares them one step after each clock edge.
module tb_sc_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic [2:0] slice_cnt;
    logic       err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [2:0] cnt;
        logic       err;
        string      tag;
    } exp_t;

    exp_t sb[$];

    sc_sched #(
        .NREQ      (4),
        .SLICE_MAX (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .slice_cnt (slice_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] oh2id(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic check(input exp_t e);
        logic [1:0] eid;
        logic       ev;
        eid = oh2id(e.gnt);
        ev  = |e.gnt;
        n_chk++;
        if (gnt !== e.gnt || gnt_valid !== ev || gnt_id !== eid ||
            slice_cnt !== e.cnt || err !== e.err) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b v=%b id=%0d cnt=%0d err=%b, want gnt=%b v=%b id=%0d cnt=%0d err=%b",
                     e.tag, gnt, gnt_valid, gnt_id, slice_cnt, err,
                     e.gnt, ev, eid, e.cnt, e.err);
        end
    endtask

    function automatic exp_t mk(
        input logic [3:0] g,
        input logic [2:0] c,
        input logic       e,
        input string      t
    );
        exp_t x;
        x.gnt = g;
        x.cnt = c;
        x.err = e;
        x.tag = t;
        return x;
    endfunction

    // Monitor: one expected entry per clock edge it was queued for.
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) check(sb.pop_front());
    end

    task automatic cyc(
        input logic [3:0] r,
        input logic [3:0] d,
        input logic [3:0] g,
        input logic [2:0] c,
        input string      t
    );
        @(negedge clk);
        req  = r;
        done = d;
        sb.push_back(mk(g, c, 1'b0, t));
    endtask

    task automatic do_reset(input string t);
        @(negedge clk);
        req   = 4'b1111;
        done  = 4'b0000;
        rst_n = 1'b0;
        #1;
        check(mk(4'b0000, 3'd0, 1'b0, t));
        repeat (3) @(posedge clk);
        #1;
        check(mk(4'b0000, 3'd0, 1'b0, {t, "_hold"}));
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] one;
        one   = 4'b0001;
        rst_n = 1'b1;
        req   = 4'b0000;
        done  = 4'b0000;

        do_reset("reset");

        for (int i = 0; i < 12; i++)
            cyc(4'b0100, 4'b0000, 4'b0100,
                (i < 5) ? 3'(i) : 3'd5, "lone");
        cyc(4'b0000, 4'b0000, 4'b0000, 3'd0, "lone_rel");
        cyc(4'b0000, 4'b0000, 4'b0000, 3'd0, "lone_idle");

        do_reset("reset2");

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 6; i++)
                cyc(4'b1111, 4'b0000, one << k, 3'(i), "rr_slice");
            cyc(4'b1111, 4'b0000, 4'b0000, 3'd0, "rr_drain");
        end
        cyc(4'b1111, 4'b0000, 4'b0001, 3'd0, "rr_wrap");

        do_reset("reset3");

        cyc(4'b0110, 4'b0000, 4'b0010, 3'd0, "er_g1");
        cyc(4'b0110, 4'b0000, 4'b0010, 3'd1, "er_c1");
        cyc(4'b0110, 4'b0000, 4'b0010, 3'd2, "er_c2");
        cyc(4'b0110, 4'b0010, 4'b0000, 3'd0, "done_rel");
        cyc(4'b0110, 4'b0000, 4'b0100, 3'd0, "er_next");
        cyc(4'b0110, 4'b1000, 4'b0100, 3'd1, "done_nonown");
        cyc(4'b0110, 4'b0000, 4'b0100, 3'd2, "er_c2b");
        cyc(4'b0110, 4'b0000, 4'b0100, 3'd3, "er_c3");

        do_reset("rst_mid");

        cyc(4'b1001, 4'b0000, 4'b0001, 3'd0, "ptr0");
        for (int i = 1; i < 6; i++)
            cyc(4'b0001, 4'b0000, 4'b0001, 3'(i), "sat_run");
        cyc(4'b0001, 4'b0000, 4'b0001, 3'd5, "sat_hold");

        @(negedge clk);
        req  = 4'b0001;
        done = 4'b0000;
        force dut.u_ctr.cnt_d = 3'b110;
        sb.push_back(mk(4'b0001, 3'd6, 1'b1, "err_set"));
        @(posedge clk);
        #2;
        release dut.u_ctr.cnt_d;
        cyc(4'b0001, 4'b0000, 4'b0000, 3'd0, "err_recover");
        cyc(4'b0001, 4'b0000, 4'b0001, 3'd0, "err_regrant");

        repeat (3) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending, want 0",
                     sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
